hpdmc_rdcapture: RTL and testbench

Read-data capture and burst assembler for the HPDMC datapath, sitting directly behind the IDDR2 input registers in the `sys_clk` domain. It takes the rising- and falling-edge halves delivered every cycle and selects the cycles that belong to a read burst using a programmable CAS delay. It packs each pair of beats into one word, tags the final word of every burst, and buffers the words in a first-word-fall-through FIFO with ready/valid backpressure. It replaces the fixed 32-bit wide, always-sampling capture path with one that is width-, burst- and depth-parametrised and has error reporting.

---
 rtl/hpdmc_rdcapture_if.sv | 24 ++
 rtl/hpdmc_rdcapture.sv | 142 ++++++++++++++
 tb/tb_hpdmc_rdcapture.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdmc_rdcapture_if.sv
// Output word stream of the HPDMC read-capture block: ready/valid handshake
// carrying one packed beat pair plus its end-of-burst tag.
interface hpdmc_rdcapture_if #(
    parameter int unsigned DQ_WIDTH = 32
);
    logic [2*DQ_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/hpdmc_rdcapture.sv
// HPDMC read-data capture: schedules capture cycles after each READ issue,
// packs beat pairs into words and buffers them in a first-word-fall-through FIFO.
module hpdmc_rdcapture #(
    parameter int unsigned DQ_WIDTH = 32,
    parameter int unsigned BEATS    = 4,
    parameter int unsigned LAT_W    = 4,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [DQ_WIDTH-1:0] q0,
    input  logic [DQ_WIDTH-1:0] q1,
    input  logic                rd_issue,
    input  logic [LAT_W-1:0]    cfg_lat,
    input  logic                cfg_swap,
    input  logic                clr_err,
    hpdmc_rdcapture_if.master   out,
    output logic                busy,
    output logic                overflow,
    output logic                collision
);
    localparam int unsigned SLOTS  = BEATS / 2;
    localparam int unsigned DL_LEN = (2 ** LAT_W) + SLOTS;
    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned HOLD_W = $clog2(SLOTS) + 1;
    localparam int unsigned EW     = 2 * DQ_WIDTH + 1;

    localparam logic [DL_LEN-1:0]  CAP_BASE  = DL_LEN'((1 << SLOTS) - 1);
    localparam logic [DL_LEN-1:0]  LAST_BASE = DL_LEN'(1) << (SLOTS - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    // Scheduling state
    logic [DL_LEN-1:0] cap_line;
    logic [DL_LEN-1:0] last_line;
    logic [HOLD_W-1:0] hold;
    logic [LAT_W-1:0]  sh_lat;
    logic              sh_swap;

    logic              accept;
    logic              reject;
    logic [LAT_W-1:0]  eff_lat;
    logic [DL_LEN-1:0] cap_mask;
    logic [DL_LEN-1:0] last_mask;

    // FIFO state
    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic                  capture;
    logic                  cap_last;
    logic [2*DQ_WIDTH-1:0] cap_word;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    assign busy    = |cap_line;
    assign accept  = rd_issue && (hold == '0);
    assign reject  = rd_issue && !accept;
    assign eff_lat = busy ? sh_lat : cfg_lat;

    // Bit n of the delay line means "capture on the (n+1)-th edge from now".
    assign cap_mask  = CAP_BASE << eff_lat;
    assign last_mask = LAST_BASE << eff_lat;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_line  <= '0;
            last_line <= '0;
            hold      <= '0;
            sh_lat    <= '0;
            sh_swap   <= 1'b0;
        end else begin
            cap_line  <= (cap_line  >> 1) | (accept ? cap_mask  : '0);
            last_line <= (last_line >> 1) | (accept ? last_mask : '0);
            if (accept)
                hold <= HOLD_W'(SLOTS - 1);
            else if (hold != '0)
                hold <= hold - 1'b1;
            if (accept && !busy) begin
                sh_lat  <= cfg_lat;
                sh_swap <= cfg_swap;
            end
        end
    end

    assign capture  = cap_line[0];
    assign cap_last = last_line[0];
    assign cap_word = sh_swap ? {q0, q1} : {q1, q0};

    assign full    = (count == FULL_CNT);
    assign pop     = out.out_valid && out.out_ready;
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem[wr_ptr] <= {cap_last, cap_word};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An error event on the same edge as clr_err takes priority.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (reject)
                collision <= 1'b1;
            else if (clr_err)
                collision <= 1'b0;
        end
    end

    // Memory is not reset, so the head entry is masked while the FIFO is empty.
    assign out.out_valid = (count != '0);
    assign out.out_data  = out.out_valid ? mem[rd_ptr][2*DQ_WIDTH-1:0] : '0;
    assign out.out_last  = out.out_valid ? mem[rd_ptr][EW-1] : 1'b0;
endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Directed and randomized bench for hpdmc_rdcapture against a queue-based
// model of burst scheduling, word packing and the output FIFO.
module tb_hpdmc_rdcapture;
    localparam int DQ    = 32;
    localparam int SLOTS = 2;
    localparam int DEPTH = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [DQ-1:0] q0, q1;
    logic          rd_issue;
    logic [3:0]    cfg_lat;
    logic          cfg_swap;
    logic          clr_err;
    logic          busy, overflow, collision;

    hpdmc_rdcapture_if #(.DQ_WIDTH(DQ)) u_if ();

    hpdmc_rdcapture #(
        .DQ_WIDTH(DQ),
        .BEATS(4),
        .LAT_W(4),
        .FIFO_AW(3)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .q0(q0),
        .q1(q1),
        .rd_issue(rd_issue),
        .cfg_lat(cfg_lat),
        .cfg_swap(cfg_swap),
        .clr_err(clr_err),
        .out(u_if),
        .busy(busy),
        .overflow(overflow),
        .collision(collision)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int unsigned edge_n;
        bit          swap;
        bit          last;
    } cap_t;

    cap_t          pend[$];
    logic [64:0]   mfifo[$];
    int            last_acc;
    int unsigned   e;
    bit            m_ovf, m_col, m_swap;
    logic [3:0]    m_lat;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_words;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mfifo.delete();
        last_acc = -100;
        m_ovf = 0;
        m_col = 0;
        m_lat = '0;
        m_swap = 0;
    endtask

    // Evaluate what the upcoming clock edge does, using the inputs the DUT will sample.
    task automatic model_edge();
        bit   busy_m, have_cap, full_m, pop_m, drop_m, rej_m;
        cap_t c;
        if (!sys_rst_n) return;
        busy_m   = pend.size() > 0;
        have_cap = 0;
        drop_m   = 0;
        rej_m    = 0;
        if (pend.size() > 0 && pend[0].edge_n == e) begin
            c = pend.pop_front();
            have_cap = 1;
        end
        full_m = mfifo.size() == DEPTH;
        pop_m  = mfifo.size() > 0 && u_if.out_ready;
        if (pop_m) void'(mfifo.pop_front());
        if (have_cap) begin
            if (!full_m || pop_m)
                mfifo.push_back({c.last, (c.swap ? {q0, q1} : {q1, q0})});
            else
                drop_m = 1;
        end
        if (rd_issue) begin
            if (int'(e) - last_acc >= SLOTS) begin
                if (!busy_m) begin
                    m_lat  = cfg_lat;
                    m_swap = cfg_swap;
                end
                for (int k = 0; k < SLOTS; k++) begin
                    cap_t n;
                    n.edge_n = e + m_lat + 1 + k;
                    n.swap   = m_swap;
                    n.last   = (k == SLOTS - 1);
                    pend.push_back(n);
                end
                last_acc = e;
            end else begin
                rej_m = 1;
            end
        end
        if (drop_m) m_ovf = 1; else if (clr_err) m_ovf = 0;
        if (rej_m)  m_col = 1; else if (clr_err) m_col = 0;
        e++;
    endtask

    task automatic check_all();
        logic [64:0] hd;
        hd = (mfifo.size() > 0) ? mfifo[0] : '0;
        check("out_valid", u_if.out_valid, mfifo.size() > 0);
        check("out_data",  u_if.out_data,  hd[63:0]);
        check("out_last",  u_if.out_last,  hd[64]);
        check("busy",      busy,           pend.size() > 0);
        check("overflow",  overflow,       m_ovf);
        check("collision", collision,      m_col);
    endtask

    task automatic step();
        if (u_if.out_valid && u_if.out_ready) n_words++;
        model_edge();
        @(posedge sys_clk);
        #1;
        check_all();
        q0       = $urandom;
        q1       = $urandom;
        rd_issue = 0;
        clr_err  = 0;
    endtask

    task automatic issue_step();
        rd_issue = 1;
        step();
    endtask

    initial begin
        sys_rst_n     = 0;
        q0            = $urandom;
        q1            = $urandom;
        rd_issue      = 0;
        cfg_lat       = 4'd3;
        cfg_swap      = 0;
        clr_err       = 0;
        u_if.out_ready = 1;
        e             = 0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_valid", u_if.out_valid, 0);
        check("rst_data",  u_if.out_data,  0);
        check("rst_busy",  busy,           0);
        check("rst_ovf",   overflow,       0);
        check("rst_col",   collision,      0);
        sys_rst_n = 1;

        // Basic capture, then swapped capture
        issue_step();
        repeat (8) step();
        cfg_swap = 1;
        issue_step();
        repeat (8) step();
        cfg_swap = 0;

        // Back-to-back issues two edges apart
        issue_step();
        step();
        issue_step();
        repeat (10) step();

        // Issue one edge after an accepted one is rejected
        issue_step();
        issue_step();
        repeat (8) step();
        check("col_set", collision, 1);
        clr_err = 1;
        step();
        check("col_clr", collision, 0);

        // Overflow: five bursts into a stalled consumer
        u_if.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            issue_step();
            step();
        end
        repeat (8) step();
        check("ovf_set", overflow, 1);
        n_words = 0;
        u_if.out_ready = 1;
        repeat (12) step();
        check("ovf_drain", n_words, 8);
        clr_err = 1;
        step();

        // Full FIFO with pop on the same edges as the last two captures
        for (int j = 0; j < 14; j++) begin
            rd_issue       = (j % 2 == 0) && (j <= 8);
            u_if.out_ready = (j >= 12);
            step();
        end
        check("full_pop_ovf", overflow, 0);
        u_if.out_ready = 1;
        repeat (12) step();

        // Reset after the first capture of a burst
        cfg_lat = 4'd2;
        issue_step();
        repeat (3) step();
        sys_rst_n = 0;
        #1;
        check("mid_rst_valid", u_if.out_valid, 0);
        check("mid_rst_data",  u_if.out_data,  0);
        check("mid_rst_last",  u_if.out_last,  0);
        check("mid_rst_busy",  busy,           0);
        model_reset();
        repeat (2) step();
        sys_rst_n = 1;
        n_words = 0;
        repeat (8) step();
        check("post_rst_words", n_words, 0);

        // Randomized traffic, then a heavily stalled phase
        for (int i = 0; i < 400; i++) begin
            rd_issue       = ($urandom_range(0, 2) == 0);
            cfg_lat        = 4'($urandom_range(0, 15));
            cfg_swap       = 1'($urandom_range(0, 1));
            clr_err        = ($urandom_range(0, 15) == 0);
            u_if.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < 200; i++) begin
            rd_issue       = ($urandom_range(0, 1) == 0);
            cfg_lat        = 4'($urandom_range(0, 6));
            cfg_swap       = 1'($urandom_range(0, 1));
            clr_err        = ($urandom_range(0, 31) == 0);
            u_if.out_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        u_if.out_ready = 1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
